// File: rtl/cam_ternary_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cam_ternary_pkg                                               |
// | Description : Shared op encodings, FSM states and depth helper for the CAM. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package cam_ternary_pkg;

    localparam logic [1:0] CAM_OP_WR_ADDR  = 2'b00;
    localparam logic [1:0] CAM_OP_WR_FREE  = 2'b01;
    localparam logic [1:0] CAM_OP_DEL_ADDR = 2'b10;
    localparam logic [1:0] CAM_OP_DEL_KEY  = 2'b11;

    localparam logic [1:0] CAM_ST_INIT = 2'd0;
    localparam logic [1:0] CAM_ST_IDLE = 2'd1;
    localparam logic [1:0] CAM_ST_EXEC = 2'd2;

    typedef enum logic [1:0] {
        ST_INIT = CAM_ST_INIT,
        ST_IDLE = CAM_ST_IDLE,
        ST_EXEC = CAM_ST_EXEC
    } cam_state_e;

    function automatic int cam_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_ternary_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cam_ternary_if                                                |
// | Description : Command, response, lookup and status signals of the CAM.     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface cam_ternary_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  write_valid;
    logic                  write_ready;
    logic [1:0]            write_op;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] write_mask;
    logic                  write_resp_valid;
    logic [ADDR_WIDTH-1:0] write_resp_addr;
    logic                  write_resp_err;

    logic                  compare_valid;
    logic [DATA_WIDTH-1:0] compare_data;
    logic                  match_valid;
    logic                  match;
    logic [ADDR_WIDTH-1:0] match_addr;
    logic [DEPTH-1:0]      match_many;
    logic                  match_multi;

    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;

    modport master (
        output write_valid, write_op, write_addr, write_data, write_mask,
        output compare_valid, compare_data,
        input  write_ready, write_resp_valid, write_resp_addr, write_resp_err,
        input  match_valid, match, match_addr, match_many, match_multi,
        input  count, full, empty
    );

    modport slave (
        input  write_valid, write_op, write_addr, write_data, write_mask,
        input  compare_valid, compare_data,
        output write_ready, write_resp_valid, write_resp_addr, write_resp_err,
        output match_valid, match, match_addr, match_many, match_multi,
        output count, full, empty
    );

endinterface
`default_nettype wire

// File: rtl/cam_ternary_priority_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cam_ternary_priority_encoder                                  |
// | Description : Index of the winning set bit; LSB_PRIORITY picks the end.     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module cam_ternary_priority_encoder #(
    parameter int    WIDTH        = 16,
    parameter string LSB_PRIORITY = "HIGH",
    localparam int   IDX_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  wire logic [WIDTH-1:0] i_vec,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_found
);

    generate
        if (LSB_PRIORITY == "HIGH") begin : g_lsb_first
            always_comb begin
                o_idx = '0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (i_vec[i]) o_idx = IDX_W'(i);
                end
            end
        end else begin : g_msb_first
            always_comb begin
                o_idx = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (i_vec[i]) o_idx = IDX_W'(i);
                end
            end
        end
    endgenerate

    assign o_found = |i_vec;

endmodule
`default_nettype wire

// File: rtl/cam_ternary.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cam_ternary                                                   |
// | Description : Register-based ternary CAM, 1-cycle lookup, command FSM.      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module cam_ternary
    import cam_ternary_pkg::*;
#(
    parameter int    DATA_WIDTH   = 16,
    parameter int    ADDR_WIDTH   = 4,
    parameter int    TERNARY      = 1,
    parameter string LSB_PRIORITY = "HIGH"
) (
    input  wire logic    clk,
    input  wire logic    rst,
    cam_ternary_if.slave bus
);

    localparam int                  DEPTH      = cam_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0]    DEPTH_ONE  = {{(DEPTH-1){1'b0}}, 1'b1};

    cam_state_e            state_q, state_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [DATA_WIDTH-1:0] mask_q [DEPTH];
    logic [DATA_WIDTH-1:0] mask_d [DEPTH];
    logic [ADDR_WIDTH:0]   count_q, count_d;

    logic [1:0]            cmd_op_q, cmd_op_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
    logic [DATA_WIDTH-1:0] cmd_mask_q, cmd_mask_d;

    logic                  resp_valid_q, resp_valid_d;
    logic [ADDR_WIDTH-1:0] resp_addr_q, resp_addr_d;
    logic                  resp_err_q, resp_err_d;

    logic                  match_valid_q, match_valid_d;
    logic                  match_q, match_d;
    logic [ADDR_WIDTH-1:0] match_addr_q, match_addr_d;
    logic [DEPTH-1:0]      match_many_q, match_many_d;
    logic                  match_multi_q, match_multi_d;

    logic                  w_write_ready;
    logic [DEPTH-1:0]      w_cmp_hits;
    logic [DEPTH-1:0]      w_del_hits;
    logic [ADDR_WIDTH:0]   w_del_count;
    logic [DEPTH-1:0]      w_tgt_vec;
    logic [ADDR_WIDTH-1:0] w_cmp_idx;
    logic                  w_cmp_found;
    logic [ADDR_WIDTH-1:0] w_tgt_idx;
    logic                  w_tgt_found;
    logic [DATA_WIDTH-1:0] w_store_mask;
    logic [DATA_WIDTH-1:0] w_store_data;

    function automatic logic entry_hit(input logic                  v,
                                       input logic [DATA_WIDTH-1:0] key,
                                       input logic [DATA_WIDTH-1:0] d,
                                       input logic [DATA_WIDTH-1:0] m);
        return v && (((key ^ d) & m) == '0);
    endfunction

    always_comb begin
        w_del_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cmp_hits[i] = entry_hit(valid_q[i], bus.compare_data, data_q[i], mask_q[i]);
            w_del_hits[i] = entry_hit(valid_q[i], cmd_data_q, data_q[i], mask_q[i]);
            w_del_count   = w_del_count + {{ADDR_WIDTH{1'b0}}, w_del_hits[i]};
        end
    end

    // The second encoder is shared: delete-by-key needs the priority hit,
    // every other op only ever looks for the priority free slot.
    assign w_tgt_vec = (cmd_op_q == CAM_OP_DEL_KEY) ? w_del_hits : ~valid_q;

    cam_ternary_priority_encoder #(
        .WIDTH        (DEPTH),
        .LSB_PRIORITY (LSB_PRIORITY)
    ) u_pe_hit (
        .i_vec   (w_cmp_hits),
        .o_idx   (w_cmp_idx),
        .o_found (w_cmp_found)
    );

    cam_ternary_priority_encoder #(
        .WIDTH        (DEPTH),
        .LSB_PRIORITY (LSB_PRIORITY)
    ) u_pe_tgt (
        .i_vec   (w_tgt_vec),
        .o_idx   (w_tgt_idx),
        .o_found (w_tgt_found)
    );

    assign w_store_mask = (TERNARY != 0) ? cmd_mask_q : '1;
    assign w_store_data = cmd_data_q & w_store_mask;

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        data_d        = data_q;
        mask_d        = mask_q;
        count_d       = count_q;
        cmd_op_d      = cmd_op_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_data_d    = cmd_data_q;
        cmd_mask_d    = cmd_mask_q;
        resp_valid_d  = 1'b0;
        resp_addr_d   = resp_addr_q;
        resp_err_d    = resp_err_q;
        w_write_ready = 1'b0;

        case (state_q)
            ST_INIT: begin
                valid_d = '0;
                count_d = '0;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                w_write_ready = 1'b1;
                if (bus.write_valid) begin
                    cmd_op_d   = bus.write_op;
                    cmd_addr_d = bus.write_addr;
                    cmd_data_d = bus.write_data;
                    cmd_mask_d = bus.write_mask;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b1;
                case (cmd_op_q)
                    CAM_OP_WR_ADDR: begin
                        data_d[cmd_addr_q]  = w_store_data;
                        mask_d[cmd_addr_q]  = w_store_mask;
                        valid_d[cmd_addr_q] = 1'b1;
                        if (!valid_q[cmd_addr_q]) count_d = count_q + COUNT_ONE;
                        resp_addr_d = cmd_addr_q;
                        resp_err_d  = 1'b0;
                    end
                    CAM_OP_WR_FREE: begin
                        if (w_tgt_found) begin
                            data_d[w_tgt_idx]  = w_store_data;
                            mask_d[w_tgt_idx]  = w_store_mask;
                            valid_d[w_tgt_idx] = 1'b1;
                            count_d     = count_q + COUNT_ONE;
                            resp_addr_d = w_tgt_idx;
                            resp_err_d  = 1'b0;
                        end else begin
                            resp_addr_d = '0;
                            resp_err_d  = 1'b1;
                        end
                    end
                    CAM_OP_DEL_ADDR: begin
                        valid_d[cmd_addr_q] = 1'b0;
                        if (valid_q[cmd_addr_q]) count_d = count_q - COUNT_ONE;
                        resp_addr_d = cmd_addr_q;
                        resp_err_d  = !valid_q[cmd_addr_q];
                    end
                    default: begin
                        valid_d     = valid_q & ~w_del_hits;
                        count_d     = count_q - w_del_count;
                        resp_addr_d = w_tgt_found ? w_tgt_idx : '0;
                        resp_err_d  = !w_tgt_found;
                    end
                endcase
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Lookups read the registered table, so a compare on a commit edge sees
    // the old contents; outputs other than match_valid hold between lookups.
    always_comb begin
        match_valid_d = bus.compare_valid;
        match_d       = match_q;
        match_addr_d  = match_addr_q;
        match_many_d  = match_many_q;
        match_multi_d = match_multi_q;
        if (bus.compare_valid) begin
            match_d       = w_cmp_found;
            match_addr_d  = w_cmp_idx;
            match_many_d  = w_cmp_hits;
            match_multi_d = |(w_cmp_hits & (w_cmp_hits - DEPTH_ONE));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_INIT;
            valid_q       <= '0;
            count_q       <= '0;
            cmd_op_q      <= '0;
            cmd_addr_q    <= '0;
            cmd_data_q    <= '0;
            cmd_mask_q    <= '0;
            resp_valid_q  <= 1'b0;
            resp_addr_q   <= '0;
            resp_err_q    <= 1'b0;
            match_valid_q <= 1'b0;
            match_q       <= 1'b0;
            match_addr_q  <= '0;
            match_many_q  <= '0;
            match_multi_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            count_q       <= count_d;
            cmd_op_q      <= cmd_op_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_data_q    <= cmd_data_d;
            cmd_mask_q    <= cmd_mask_d;
            resp_valid_q  <= resp_valid_d;
            resp_addr_q   <= resp_addr_d;
            resp_err_q    <= resp_err_d;
            match_valid_q <= match_valid_d;
            match_q       <= match_d;
            match_addr_q  <= match_addr_d;
            match_many_q  <= match_many_d;
            match_multi_q <= match_multi_d;
        end
    end

    // Key storage carries no reset; valid_q alone qualifies an entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= data_d;
            mask_q <= mask_d;
        end
    end

    assign bus.write_ready      = w_write_ready;
    assign bus.write_resp_valid = resp_valid_q;
    assign bus.write_resp_addr  = resp_addr_q;
    assign bus.write_resp_err   = resp_err_q;
    assign bus.match_valid      = match_valid_q;
    assign bus.match            = match_q;
    assign bus.match_addr       = match_addr_q;
    assign bus.match_many       = match_many_q;
    assign bus.match_multi      = match_multi_q;
    assign bus.count            = count_q;
    assign bus.full             = (count_q == FULL_COUNT);
    assign bus.empty            = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_cam_ternary.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cam_ternary                                                |
// | Description : Directed vector table plus corner sequences for cam_ternary. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_cam_ternary;
    import cam_ternary_pkg::*;

    typedef struct {
        bit          is_cmp;
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [15:0] mask;
        logic [3:0]  exp_addr;
        logic        exp_err;
        logic [4:0]  exp_count;
        logic        exp_match;
        logic [15:0] exp_many;
        logic        exp_multi;
    } vec_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl_a [17];
    vec_t tbl_b [18];

    cam_ternary_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

    cam_ternary #(
        .DATA_WIDTH   (16),
        .ADDR_WIDTH   (4),
        .TERNARY      (1),
        .LSB_PRIORITY ("HIGH")
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk_cmd(input logic [1:0] op, input logic [3:0] addr,
                                    input logic [15:0] data, input logic [15:0] mask,
                                    input logic [3:0] ea, input logic ee, input logic [4:0] ec);
        vec_t v;
        v = '{is_cmp: 1'b0, op: op, addr: addr, data: data, mask: mask,
              exp_addr: ea, exp_err: ee, exp_count: ec,
              exp_match: 1'b0, exp_many: 16'h0, exp_multi: 1'b0};
        return v;
    endfunction

    function automatic vec_t mk_cmp(input logic [15:0] key, input logic em, input logic [3:0] ea,
                                    input logic [15:0] emany, input logic emulti);
        vec_t v;
        v = '{is_cmp: 1'b1, op: 2'b00, addr: 4'h0, data: key, mask: 16'h0,
              exp_addr: ea, exp_err: 1'b0, exp_count: 5'd0,
              exp_match: em, exp_many: emany, exp_multi: emulti};
        return v;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.write_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.write_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s wait_ready: timed out, write_ready=%b", tag, bus.write_ready);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] addr,
                         input logic [15:0] data, input logic [15:0] mask, input string tag);
        wait_ready(tag);
        bus.write_valid = 1'b1;
        bus.write_op    = op;
        bus.write_addr  = addr;
        bus.write_data  = data;
        bus.write_mask  = mask;
        tick();
        bus.write_valid = 1'b0;
        check({tag, " exec_ready"}, bus.write_ready, 0);
        check({tag, " early_resp"}, bus.write_resp_valid, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        if (v.is_cmp) begin
            bus.compare_valid = 1'b1;
            bus.compare_data  = v.data;
            tick();
            bus.compare_valid = 1'b0;
            check({tag, " match_valid"}, bus.match_valid, 1);
            check({tag, " match"}, bus.match, v.exp_match);
            check({tag, " match_many"}, bus.match_many, v.exp_many);
            check({tag, " match_multi"}, bus.match_multi, v.exp_multi);
            if (v.exp_match) check({tag, " match_addr"}, bus.match_addr, v.exp_addr);
        end else begin
            issue(v.op, v.addr, v.data, v.mask, tag);
            tick();
            check({tag, " resp_valid"}, bus.write_resp_valid, 1);
            check({tag, " resp_addr"}, bus.write_resp_addr, v.exp_addr);
            check({tag, " resp_err"}, bus.write_resp_err, v.exp_err);
            check({tag, " count"}, bus.count, v.exp_count);
            check({tag, " ready_with_resp"}, bus.write_ready, 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            tbl_a[i] = mk_cmd(CAM_OP_WR_FREE, 4'h0, 16'h1000 + 16'(i), 16'hFFFF, 4'(i), 1'b0, 5'(i + 1));
        tbl_a[16] = mk_cmd(CAM_OP_WR_FREE, 4'h0, 16'h2000, 16'hFFFF, 4'h0, 1'b1, 5'd16);

        tbl_b[0]  = mk_cmd(CAM_OP_WR_ADDR,  4'd3, 16'hAB00, 16'hFF00, 4'd3, 1'b0, 5'd1);
        tbl_b[1]  = mk_cmd(CAM_OP_WR_ADDR,  4'd7, 16'hABCD, 16'hFFFF, 4'd7, 1'b0, 5'd2);
        tbl_b[2]  = mk_cmp(16'hABCD, 1'b1, 4'd3, 16'h0088, 1'b1);
        tbl_b[3]  = mk_cmp(16'hAB12, 1'b1, 4'd3, 16'h0008, 1'b0);
        tbl_b[4]  = mk_cmp(16'h1234, 1'b0, 4'd0, 16'h0000, 1'b0);
        tbl_b[5]  = mk_cmd(CAM_OP_DEL_KEY,  4'd0, 16'hABCD, 16'hFFFF, 4'd3, 1'b0, 5'd0);
        tbl_b[6]  = mk_cmd(CAM_OP_DEL_KEY,  4'd0, 16'hABCD, 16'hFFFF, 4'd0, 1'b1, 5'd0);
        tbl_b[7]  = mk_cmd(CAM_OP_DEL_ADDR, 4'd5, 16'h0000, 16'h0000, 4'd5, 1'b1, 5'd0);
        tbl_b[8]  = mk_cmd(CAM_OP_WR_ADDR,  4'd5, 16'h1234, 16'hFFFF, 4'd5, 1'b0, 5'd1);
        tbl_b[9]  = mk_cmd(CAM_OP_WR_ADDR,  4'd5, 16'h4321, 16'hFFFF, 4'd5, 1'b0, 5'd1);
        tbl_b[10] = mk_cmp(16'h4321, 1'b1, 4'd5, 16'h0020, 1'b0);
        tbl_b[11] = mk_cmd(CAM_OP_DEL_ADDR, 4'd5, 16'h0000, 16'h0000, 4'd5, 1'b0, 5'd0);
        tbl_b[12] = mk_cmd(CAM_OP_WR_ADDR,  4'd2, 16'hFFFF, 16'h00F0, 4'd2, 1'b0, 5'd1);
        tbl_b[13] = mk_cmp(16'h12F4, 1'b1, 4'd2, 16'h0004, 1'b0);
        tbl_b[14] = mk_cmp(16'h1204, 1'b0, 4'd0, 16'h0000, 1'b0);
        tbl_b[15] = mk_cmd(CAM_OP_WR_FREE,  4'd0, 16'h7777, 16'hFFFF, 4'd0, 1'b0, 5'd2);
        tbl_b[16] = mk_cmp(16'h7777, 1'b1, 4'd0, 16'h0001, 1'b0);
        tbl_b[17] = mk_cmd(CAM_OP_DEL_KEY,  4'd0, 16'h77F7, 16'hFFFF, 4'd2, 1'b0, 5'd1);

        rst               = 1'b0;
        bus.write_valid   = 1'b0;
        bus.write_op      = 2'b00;
        bus.write_addr    = 4'h0;
        bus.write_data    = 16'h0;
        bus.write_mask    = 16'h0;
        bus.compare_valid = 1'b0;
        bus.compare_data  = 16'h0;

        tick();
        tick();
        check("rst write_ready", bus.write_ready, 0);
        check("rst count", bus.count, 0);
        check("rst empty", bus.empty, 1);
        check("rst full", bus.full, 0);
        check("rst match_valid", bus.match_valid, 0);
        check("rst match", bus.match, 0);
        check("rst match_many", bus.match_many, 0);
        check("rst match_addr", bus.match_addr, 0);
        check("rst resp_valid", bus.write_resp_valid, 0);

        rst = 1'b1;
        check("init write_ready", bus.write_ready, 0);
        tick();
        check("idle write_ready", bus.write_ready, 1);
        check("idle empty", bus.empty, 1);
        run_vec(mk_cmp(16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0), "cmp_empty");

        for (int i = 0; i < 17; i++) run_vec(tbl_a[i], $sformatf("fill%0d", i));
        check("fill full", bus.full, 1);
        check("fill empty", bus.empty, 0);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rerst count", bus.count, 0);

        for (int i = 0; i < 18; i++) run_vec(tbl_b[i], $sformatf("row%0d", i));

        // Compare accepted on the commit edge must see the old table.
        issue(CAM_OP_WR_ADDR, 4'd9, 16'h5555, 16'hFFFF, "same");
        bus.compare_valid = 1'b1;
        bus.compare_data  = 16'h5555;
        tick();
        check("same resp_valid", bus.write_resp_valid, 1);
        check("same first match_valid", bus.match_valid, 1);
        check("same first match", bus.match, 0);
        check("same count", bus.count, 2);
        tick();
        check("same second match", bus.match, 1);
        check("same second match_addr", bus.match_addr, 9);
        bus.compare_valid = 1'b0;
        tick();
        check("hold match_valid", bus.match_valid, 0);
        check("hold match", bus.match, 1);
        check("hold match_addr", bus.match_addr, 9);
        check("hold match_many", bus.match_many, 16'h0200);

        // Reset landing on the EXEC cycle aborts the op.
        issue(CAM_OP_WR_ADDR, 4'd4, 16'h4444, 16'hFFFF, "abort");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort resp_valid", bus.write_resp_valid, 0);
        check("abort count", bus.count, 0);
        check("abort empty", bus.empty, 1);
        check("abort write_ready", bus.write_ready, 0);
        tick();
        check("abort late resp_valid", bus.write_resp_valid, 0);
        check("abort ready back", bus.write_ready, 1);
        run_vec(mk_cmp(16'h4444, 1'b0, 4'd0, 16'h0000, 1'b0), "abort_cmp4444");
        run_vec(mk_cmp(16'h5555, 1'b0, 4'd0, 16'h0000, 1'b0), "abort_cmp5555");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cam_ternary.md
# cam_ternary

Register-based ternary content-addressable memory for the lookup path, the next generation of the BRAM-based CAM. It adds per-entry masks, valid bits, an allocate-first-free write, delete-by-key and occupancy flags. It also replaces the free-running compare with a pipelined compare handshake. Lookups complete in one cycle at full rate; table updates run through a small command FSM with a response strobe.

## Interface
- DATA_WIDTH, 16, key width in bits
- ADDR_WIDTH, 4, log2 of entry count; DEPTH = 2**ADDR_WIDTH
- TERNARY, 1, 1 = write_mask stored per entry; 0 = mask forced all-ones (binary CAM)
- LSB_PRIORITY, "HIGH", "HIGH" = lowest index wins in match_addr and free-slot search; "LOW" = highest index wins
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- write_valid  in  1  command request
- write_ready  out  1  command accepted when write_valid & write_ready
- write_op  in  2  00 write-at-addr, 01 write-first-free, 10 delete-at-addr, 11 delete-by-key
- write_addr  in  ADDR_WIDTH  target entry for ops 00 and 10
- write_data  in  DATA_WIDTH  key for ops 00, 01 and 11
- write_mask  in  DATA_WIDTH  1 = bit compared, 0 = don't care
- write_resp_valid  out  1  one-cycle completion strobe
- write_resp_addr  out  ADDR_WIDTH  entry written or deleted; for op 11, the priority entry cleared
- write_resp_err  out  1  op 01 with table full; op 10 on an invalid entry; op 11 with no entry cleared
- compare_valid  in  1  lookup request; no backpressure
- compare_data  in  DATA_WIDTH  lookup key
- match_valid  out  1  lookup result valid
- match  out  1  at least one entry hit
- match_addr  out  ADDR_WIDTH  priority hit index
- match_many  out  DEPTH  raw hit vector
- match_multi  out  1  more than one hit
- count  out  ADDR_WIDTH+1  valid entries
- full / empty  out  1  count==DEPTH / count==0

## Operation
- Entry i holds data[i], mask[i] and valid[i].
- Entry i hits when valid[i] & (((key ^ data[i]) & mask[i]) == 0).
- A write stores data = write_data & write_mask. Bits with mask 0 are stored as 0.
- FSM states:
  - INIT: entered on reset; clears all valid bits; lasts 1 cycle, then IDLE.
  - IDLE: write_ready=1; a handshake latches the op, addr, data and mask, then goes to EXEC.
  - EXEC: write_ready=0; computes the target and commits at the end of the cycle; goes to IDLE.
- Op 00: overwrites entry write_addr whether or not it was valid and sets valid. err=0.
- Op 01: targets the priority invalid entry. If the table is full, no change and err=1; resp_addr=0.
- Op 10: clears valid[write_addr]. err=1 if the entry was already invalid; the clear still happens.
- Op 11: evaluates the latched key with the hit function. It clears every hitting entry. resp_addr = priority cleared index. err=1 and resp_addr=0 if nothing hit.
- count is updated in the same edge as the commit. An overwrite of a valid entry leaves count unchanged.

## Timing
- Reset values while rst=0 and one cycle after: all valid bits 0, count=0, empty=1, full=0, write_ready=0. All match_* outputs, write_resp_* and match_many are 0.
- write_ready rises in the first IDLE cycle, which is the 2nd cycle after rst deasserts.
- Command throughput is 1 op per 2 cycles.
- write_resp_valid is high in the cycle after EXEC, coincident with the next IDLE cycle. A new command may handshake in that same cycle.
- Lookup latency is 1 cycle: compare_valid at edge N gives match_valid and results after edge N.
- A lookup accepted on a commit edge sees the pre-commit table. The commit becomes visible to compares accepted on the following edge.
- Reset mid-EXEC aborts the op: no commit and no response.
- When compare_valid=0, match_valid=0 and the other match outputs hold their last value.

## Structure
- Shared include cam_defs.vh holds the op encodings CAM_OP_WR_ADDR, CAM_OP_WR_FREE, CAM_OP_DEL_ADDR, CAM_OP_DEL_KEY, the FSM state encodings, and the DEPTH derivation.
- Reuse the existing priority_encoder sub-module, instantiated twice: once on the hit vector, once on ~valid for the free-slot search. Pass LSB_PRIORITY through to both.
- Popcount for match_multi: a match_many & (match_many-1) nonzero test suffices. count is an incremental counter.

## Test plan
All scenarios use DATA_WIDTH=16, ADDR_WIDTH=4.
- Reset release: write_ready=0 for 1 cycle then 1; empty=1; compare 0x0000 -> match_valid=1, match=0.
- Op 01 ×16 with keys 0x1000+i: resp_addr 0..15, err=0, full=1. A 17th op -> err=1 and count stays 16.
- Ternary: op 00 addr 3, data 0xAB00, mask 0xFF00; op 00 addr 7, data 0xABCD, mask 0xFFFF. Compare 0xABCD -> match_many has bits 3 and 7, match_addr=3, match_multi=1. Compare 0xAB12 -> only bit 3.
- Op 11 with key 0xABCD on that table: clears entries 3 and 7, resp_addr=3, count decreases by 2. Repeating the op -> err=1.
- Same-cycle compare: compare 0x5555 is accepted on the edge where op 00 writes 0x5555 -> match=0. The next compare -> match=1.
- Op 10 on an invalid entry -> err=1. Assert rst during EXEC -> no write_resp_valid and the table is empty.
